hack_prog_loader: RTL and testbench
===================================

// Module: hack_prog_loader
// PURPOSE
//  Byte-stream program loader for the Hack CPU instruction memory: the write side of the instruction path.
//  - Receives a framed byte stream over a valid/ready interface.
//  - Packs bytes into 16-bit instructions and writes them sequentially into instruction ROM from address 0.
//  - Holds the CPU in reset while loading; releases it only after a verified load.
//  - Sits between the host link (UART/testbench byte source) and the ROM write port in the top level.
// PARAMETERS
//  ADDR_W          15          ROM address width (words)
//  MAX_WORDS       32768       largest legal program length; must be <= 2**ADDR_W
//  TIMEOUT_CYCLES  50000000    idle cycles allowed between bytes mid-frame before abort
// PORTS
//  CLK_50        in   1       clock; all logic on rising edge
//  resetN        in   1       synchronous, active-low reset
//  start         in   1       arm/re-arm loader (level sampled each cycle)
//  rx_data       in   8       incoming byte
//  rx_valid      in   1       rx_data valid
//  rx_ready      out  1       loader accepts byte this cycle
//  rom_we        out  1       one-cycle ROM write strobe
//  rom_addr      out  ADDR_W  ROM write address
//  rom_wdata     out  16      ROM write data
//  cpu_resetN    out  1       active-low CPU reset (0 = CPU held)
//  loading       out  1       frame in progress
//  done          out  1       one-cycle pulse: load verified
//  error         out  1       sticky: frame rejected
//  words_loaded  out  16      instructions written in current/last frame
// BEHAVIOUR
//  - Frame format: 0xA5, CNT_HI, CNT_LO, then 2*CNT instruction bytes (big-endian, high byte first), then CSUM.
//    CSUM is the XOR of all instruction bytes.
//  - Handshake: a byte is consumed on a rising edge with rx_valid && rx_ready.
//    - rx_ready is a registered function of state: 1 in MAGIC..CSUM, 0 in IDLE/ERR.
//    - rx_data may change only after acceptance.
//  - FSM: IDLE -> MAGIC -> CNT_HI -> CNT_LO -> DATA_HI <-> DATA_LO -> CSUM -> IDLE | ERR.
//  - IDLE: cpu_resetN=1. start=1 -> MAGIC.
//  - MAGIC: cpu_resetN=0. A non-0xA5 byte is discarded (resync) and the FSM stays in MAGIC. 0xA5 -> CNT_HI.
//  - CNT_LO: 16-bit CNT assembled.
//    - CNT==0 or CNT>MAX_WORDS -> ERR.
//    - Otherwise addr<=0, words_loaded<=0, csum<=0 -> DATA_HI.
//  - DATA_LO accept: rom_wdata={hi,lo}, rom_addr=addr, rom_we=1 for exactly the next cycle.
//    - addr++ and words_loaded++ on that cycle.
//    - Last word -> CSUM, else DATA_HI.
//    - ROM write latency: 1 cycle after the low byte handshake.
//  - CSUM:
//    - Byte == running XOR -> done=1 for one cycle, state IDLE, cpu_resetN=1 on that same cycle.
//    - Mismatch -> ERR.
//  - ERR: error=1 (sticky), cpu_resetN=0, rx_ready=0. start=1 -> clears error -> MAGIC.
//  - Timeout: in CNT_HI..CSUM, a cycle counter resets on each accepted byte.
//    Reaching TIMEOUT_CYCLES -> ERR. MAGIC never times out.
//  - start=1 while in CNT_HI..CSUM: abort frame -> MAGIC. Words already written stay in ROM; words_loaded is kept.
//  - Address never wraps: CNT<=MAX_WORDS<=2**ADDR_W guarantees it.
//  - loading=1 in CNT_HI..CSUM.
//  - Reset values (also on reset mid-frame): state IDLE, cpu_resetN=0, rx_ready=0, rom_we=0, rom_addr=0,
//    rom_wdata=0, loading=0, done=0, error=0, words_loaded=0.
//    cpu_resetN rises the first cycle after resetN deasserts.
// TESTING
//  - Golden load: start; A5 00 02 12 34 80 10 CSUM=0xB6 -> exactly 2 writes: (0,0x1234), (1,0x8010).
//    done pulses once, cpu_resetN=1, words_loaded=2.
//  - Bad checksum: same frame with CSUM=0xB7 -> both writes occur, error=1, cpu_resetN stays 0.
//    start then clears error.
//  - Resync and length check: 00 FF A5 00 00 -> the two leading bytes are ignored; CNT=0 -> error=1, zero writes.
//  - Backpressure/stall: rx_valid toggled 1/0 every cycle on the golden frame -> same writes, one rom_we per word.
//    With TIMEOUT_CYCLES=8, a 9-cycle gap after CNT_LO -> ERR.
//  - Abort: start re-asserted after the first word -> FSM back in MAGIC, rom_addr restarts at 0 on the next frame.
//  - Reset mid-frame: resetN=0 during DATA_LO -> all outputs at reset values next cycle, no rom_we.

Source files
------------

// File: rtl/hack_prog_loader_if.sv
`timescale 1ns/1ps
// hack_prog_loader_if
// Bundles the two data paths of the program loader:
//   - byte stream from the host link (rx_data/rx_valid/rx_ready)
//   - ROM write port towards the instruction memory (rom_we/rom_addr/rom_wdata)
// Modports:
//   master : host/byte-source side (drives rx_data, rx_valid; observes the rest)
//   slave  : loader side (consumes bytes, drives rx_ready and the ROM write port)
interface hack_prog_loader_if #(
    parameter int ADDR_W = 15
) ();
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_wdata;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  rom_we,
        input  rom_addr,
        input  rom_wdata
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output rom_we,
        output rom_addr,
        output rom_wdata
    );
endinterface

// File: rtl/hack_prog_loader.sv
`timescale 1ns/1ps
// hack_prog_loader
// Loads a framed byte stream into the Hack instruction ROM and keeps the CPU
// in reset until a load has been verified by its checksum.
// Frame: 0xA5, CNT_HI, CNT_LO, 2*CNT instruction bytes (high byte first), CSUM
// where CSUM is the XOR of all instruction bytes.
// Ports:
//   CLK_50        clock, rising edge
//   resetN        synchronous active-low reset
//   start         arm / re-arm / abort request (level)
//   bus           slave side of hack_prog_loader_if (byte stream in, ROM write out)
//   cpu_resetN    active-low CPU reset, 0 while not idle
//   loading       frame in progress (count, data or checksum phase)
//   done          one-cycle pulse when a load is verified
//   error         high while the loader sits in the error state
//   words_loaded  instructions written in the current/last frame
module hack_prog_loader #(
    parameter int ADDR_W         = 15,
    parameter int MAX_WORDS      = 32768,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                CLK_50,
    input  logic                resetN,
    input  logic                start,
    hack_prog_loader_if.slave   bus,
    output logic                cpu_resetN,
    output logic                loading,
    output logic                done,
    output logic                error,
    output logic [15:0]         words_loaded
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] MAGIC   = 3'd1;
    localparam logic [2:0] CNT_HI  = 3'd2;
    localparam logic [2:0] CNT_LO  = 3'd3;
    localparam logic [2:0] DATA_HI = 3'd4;
    localparam logic [2:0] DATA_LO = 3'd5;
    localparam logic [2:0] CSUM    = 3'd6;
    localparam logic [2:0] ERR     = 3'd7;

    localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]        MAX_CNT    = 17'(MAX_WORDS);
    localparam logic [ADDR_W-1:0]  ADDR_ONE   = ADDR_W'(1);

    logic [2:0]         state;
    logic [2:0]         next_state;
    logic [7:0]         cnt_hi;
    logic [15:0]        cnt;
    logic [7:0]         hi_byte;
    logic [7:0]         csum;
    logic [ADDR_W-1:0]  addr;
    logic [TIMER_W-1:0] timer;
    logic               rom_we_q;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic [15:0]        rom_wdata_q;

    logic               accept;
    logic               in_frame;
    logic               next_in_frame;
    logic               abort;
    logic               take;
    logic               timed_out;
    logic [15:0]        cnt_new;
    logic               cnt_bad;
    logic               last_word;

    // rx_ready is decoded from the state register only, so it is stable for
    // the whole cycle and never depends on rx_valid.
    assign bus.rx_ready  = (state != IDLE) && (state != ERR);
    assign bus.rom_we    = rom_we_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.rom_wdata = rom_wdata_q;

    assign accept        = bus.rx_valid && bus.rx_ready;
    assign in_frame      = (state >= CNT_HI) && (state <= CSUM);
    assign next_in_frame = (next_state >= CNT_HI) && (next_state <= CSUM);
    // An abort wins over a byte arriving in the same cycle; that byte is dropped.
    assign abort         = in_frame && start;
    assign take          = accept && !abort;
    assign timed_out     = in_frame && !accept && (timer == TIMER_LAST);
    assign cnt_new       = {cnt_hi, bus.rx_data};
    assign cnt_bad       = (cnt_new == 16'd0) || ({1'b0, cnt_new} > MAX_CNT);
    assign last_word     = (words_loaded + 16'd1) == cnt;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = MAGIC;
            // Anything other than the magic byte is silently discarded so the
            // loader can lock onto a frame in the middle of line noise.
            MAGIC:   if (accept && bus.rx_data == 8'hA5) next_state = CNT_HI;
            CNT_HI:  if (accept) next_state = CNT_LO;
            CNT_LO:  if (accept) next_state = cnt_bad ? ERR : DATA_HI;
            DATA_HI: if (accept) next_state = DATA_LO;
            DATA_LO: if (accept) next_state = last_word ? CSUM : DATA_HI;
            CSUM:    if (accept) next_state = (bus.rx_data == csum) ? IDLE : ERR;
            ERR:     if (start) next_state = MAGIC;
            default: next_state = IDLE;
        endcase
        if (abort) begin
            next_state = MAGIC;
        end else if (timed_out) begin
            next_state = ERR;
        end
    end

    always_ff @(posedge CLK_50) begin
        if (!resetN) begin
            state        <= IDLE;
            cnt_hi       <= 8'd0;
            cnt          <= 16'd0;
            hi_byte      <= 8'd0;
            csum         <= 8'd0;
            addr         <= '0;
            timer        <= '0;
            rom_we_q     <= 1'b0;
            rom_addr_q   <= '0;
            rom_wdata_q  <= 16'd0;
            cpu_resetN   <= 1'b0;
            loading      <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            state      <= next_state;
            rom_we_q   <= 1'b0;
            // Outputs follow next_state so they line up with the state they describe.
            cpu_resetN <= (next_state == IDLE);
            loading    <= next_in_frame;
            error      <= (next_state == ERR);
            done       <= (state == CSUM) && (next_state == IDLE);

            // Idle-gap counter: only runs mid-frame, cleared by every byte.
            if (!in_frame || accept) begin
                timer <= '0;
            end else if (!timed_out) begin
                timer <= timer + TIMER_W'(1);
            end

            if (take) begin
                case (state)
                    CNT_HI: cnt_hi <= bus.rx_data;
                    CNT_LO: begin
                        if (!cnt_bad) begin
                            cnt          <= cnt_new;
                            addr         <= '0;
                            words_loaded <= 16'd0;
                            csum         <= 8'd0;
                        end
                    end
                    DATA_HI: begin
                        hi_byte <= bus.rx_data;
                        csum    <= csum ^ bus.rx_data;
                    end
                    DATA_LO: begin
                        rom_we_q     <= 1'b1;
                        rom_addr_q   <= addr;
                        rom_wdata_q  <= {hi_byte, bus.rx_data};
                        addr         <= addr + ADDR_ONE;
                        words_loaded <= words_loaded + 16'd1;
                        csum         <= csum ^ bus.rx_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hack_prog_loader.sv
`timescale 1ns/1ps
// tb_hack_prog_loader
// Drives framed byte streams into hack_prog_loader and compares the ROM writes
// and status outputs with a frame-parsing reference model.
module tb_hack_prog_loader;

    localparam int ADDR_W         = 15;
    localparam int MAX_WORDS      = 16;
    localparam int TIMEOUT_CYCLES = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        cpu_reset_n;
    logic        loading;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    hack_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    hack_prog_loader #(
        .ADDR_W(ADDR_W),
        .MAX_WORDS(MAX_WORDS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .CLK_50(clk),
        .resetN(rst_n),
        .start(start),
        .bus(bus),
        .cpu_resetN(cpu_reset_n),
        .loading(loading),
        .done(done),
        .error(error),
        .words_loaded(words_loaded)
    );

    always #10 clk = ~clk;

    int          check_count = 0;
    int          pass_count  = 0;
    logic [7:0]  frame[$];
    int          obs_addr[$];
    logic [15:0] obs_data[$];
    int          done_count;
    logic        cpu_at_done;
    int          exp_addr[$];
    logic [15:0] exp_data[$];
    logic        exp_done;
    logic        exp_error;
    logic [15:0] exp_words;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Passive monitor of the ROM port and the done pulse.
    always @(negedge clk) begin
        if (bus.rom_we === 1'b1) begin
            obs_addr.push_back(int'(bus.rom_addr));
            obs_data.push_back(bus.rom_wdata);
        end
        if (done === 1'b1) begin
            done_count++;
            cpu_at_done = cpu_reset_n;
        end
    end

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        done_count  = 0;
        cpu_at_done = 1'b0;
    endtask

    // Called on a falling edge; returns on a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sends every byte of 'frame', waiting a bounded time for rx_ready and
    // leaving a random idle gap of min_gap..max_gap cycles after each byte.
    task automatic applyStimulus(input int min_gap, input int max_gap);
        int waited;
        foreach (frame[k]) begin
            waited = 0;
            bus.rx_data  = frame[k];
            bus.rx_valid = 1'b1;
            while (bus.rx_ready !== 1'b1 && waited < 64) begin
                @(negedge clk);
                waited++;
            end
            if (bus.rx_ready !== 1'b1) begin
                checkOutput("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
                bus.rx_valid = 1'b0;
                return;
            end
            @(negedge clk);
            bus.rx_valid = 1'b0;
            repeat ($urandom_range(max_gap, min_gap)) @(negedge clk);
        end
    endtask

    // Reference model: parses a complete frame the way the host protocol defines it.
    task automatic model_frame();
        int         i;
        int         cnt;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        exp_done  = 1'b0;
        exp_error = 1'b0;
        i = 0;
        while (i < frame.size() && frame[i] != 8'hA5) i++;
        i++;
        cnt = int'({frame[i], frame[i+1]});
        i += 2;
        if (cnt == 0 || cnt > MAX_WORDS) begin
            exp_error = 1'b1;
            return;
        end
        x = 8'd0;
        for (int w = 0; w < cnt; w++) begin
            exp_addr.push_back(w);
            exp_data.push_back({frame[i], frame[i+1]});
            x = x ^ frame[i] ^ frame[i+1];
            i += 2;
        end
        exp_words = 16'(cnt);
        if (frame[i] == x) exp_done = 1'b1;
        else               exp_error = 1'b1;
    endtask

    task automatic check_frame(input string tag);
        repeat (3) @(negedge clk);
        checkOutput({tag, "_nwrites"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
        for (int w = 0; w < exp_addr.size() && w < obs_addr.size(); w++) begin
            checkOutput($sformatf("%s_addr%0d", tag, w), 32'(obs_addr[w]), 32'(exp_addr[w]));
            checkOutput($sformatf("%s_data%0d", tag, w), 32'(obs_data[w]), 32'(exp_data[w]));
        end
        checkOutput({tag, "_done_pulses"}, 32'(done_count), exp_done ? 32'd1 : 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'(exp_error));
        checkOutput({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'(exp_done));
        checkOutput({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
        checkOutput({tag, "_loading"}, 32'(loading), 32'd0);
        if (exp_done) checkOutput({tag, "_cpu_at_done"}, 32'(cpu_at_done), 32'd1);
    endtask

    task automatic run_frame(input string tag, input int min_gap, input int max_gap);
        clear_obs();
        pulse_start();
        applyStimulus(min_gap, max_gap);
        model_frame();
        check_frame(tag);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        exp_words    = 16'd0;
        clear_obs();
        repeat (3) @(negedge clk);

        checkOutput("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        checkOutput("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        checkOutput("rst_rom_we", 32'(bus.rom_we), 32'd0);
        checkOutput("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        checkOutput("rst_rom_wdata", 32'(bus.rom_wdata), 32'd0);
        checkOutput("rst_loading", 32'(loading), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_words", 32'(words_loaded), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rel_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
        checkOutput("rel_rx_ready", 32'(bus.rx_ready), 32'd0);

        frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h80, 8'h10, 8'hB6};
        run_frame("golden", 0, 0);

        frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h80, 8'h10, 8'hB7};
        run_frame("bad_csum", 0, 0);
        pulse_start();
        checkOutput("err_clear", 32'(error), 32'd0);
        checkOutput("err_clear_rx_ready", 32'(bus.rx_ready), 32'd1);

        frame = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
        run_frame("resync_cnt0", 0, 0);

        frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h80, 8'h10, 8'hB6};
        run_frame("toggle_valid", 1, 1);

        // Nine idle cycles after the count exceeds the 8-cycle limit.
        clear_obs();
        pulse_start();
        frame = '{8'hA5, 8'h00, 8'h02};
        applyStimulus(0, 0);
        repeat (9) @(negedge clk);
        checkOutput("timeout_error", 32'(error), 32'd1);
        checkOutput("timeout_loading", 32'(loading), 32'd0);
        checkOutput("timeout_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        checkOutput("timeout_nwrites", 32'(obs_addr.size()), 32'd0);

        // Abort after the first word of a three-word frame.
        clear_obs();
        pulse_start();
        frame = '{8'hA5, 8'h00, 8'h03, 8'h12, 8'h34};
        applyStimulus(0, 0);
        pulse_start();
        @(negedge clk);
        checkOutput("abort_loading", 32'(loading), 32'd0);
        checkOutput("abort_rx_ready", 32'(bus.rx_ready), 32'd1);
        checkOutput("abort_error", 32'(error), 32'd0);
        checkOutput("abort_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        checkOutput("abort_words", 32'(words_loaded), 32'd1);
        checkOutput("abort_nwrites", 32'(obs_addr.size()), 32'd1);
        exp_words = 16'd1;
        frame = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h80, 8'h10, 8'hB6};
        run_frame("after_abort", 0, 0);

        for (int t = 0; t < 8; t++) begin
            int         junk;
            int         cnt;
            logic [7:0] x;
            logic [7:0] b;
            frame.delete();
            junk = $urandom_range(2, 0);
            repeat (junk) frame.push_back(8'($urandom_range(127, 0)));
            frame.push_back(8'hA5);
            cnt = (t == 0) ? MAX_WORDS : (t == 1) ? MAX_WORDS + 1 : $urandom_range(MAX_WORDS, 1);
            frame.push_back(8'(cnt >> 8));
            frame.push_back(8'(cnt));
            if (cnt <= MAX_WORDS) begin
                x = 8'd0;
                repeat (2 * cnt) begin
                    b = 8'($urandom);
                    frame.push_back(b);
                    x = x ^ b;
                end
                frame.push_back(($urandom_range(3, 0) == 0) ? (x ^ 8'h01) : x);
            end
            run_frame($sformatf("rand%0d", t), 0, 3);
        end

        // Reset lands on the edge that would accept the low data byte.
        clear_obs();
        pulse_start();
        frame = '{8'hA5, 8'h00, 8'h02, 8'h12};
        applyStimulus(0, 0);
        bus.rx_data  = 8'h34;
        bus.rx_valid = 1'b1;
        rst_n        = 1'b0;
        @(negedge clk);
        checkOutput("midrst_rom_we", 32'(bus.rom_we), 32'd0);
        checkOutput("midrst_rom_addr", 32'(bus.rom_addr), 32'd0);
        checkOutput("midrst_rom_wdata", 32'(bus.rom_wdata), 32'd0);
        checkOutput("midrst_loading", 32'(loading), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_error", 32'(error), 32'd0);
        checkOutput("midrst_words", 32'(words_loaded), 32'd0);
        checkOutput("midrst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        checkOutput("midrst_rx_ready", 32'(bus.rx_ready), 32'd0);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        checkOutput("midrst_nwrites", 32'(obs_addr.size()), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_rel_cpu_reset_n", 32'(cpu_reset_n), 32'd1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
